seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
Sequential unsigned 32x32 multiplier controller. It time-shares one 32-bit ripple-carry adder (full-adder chain) over 32 shift-add iterations to produce a 64-bit product. It sits beside the ALU as the multi-cycle MUL engine. It gives the control unit a start/busy/done handshake.

Parameters:
DATA_WIDTH, 32, operand width; equals `DATA_INDEX_LIMIT+1
CNT_WIDTH, 6, iteration counter width; must hold the value DATA_WIDTH

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request pulse; sampled only in IDLE or DONE
OP1  input  DATA_WIDTH  multiplicand; latched on accepted START
OP2  input  DATA_WIDTH  multiplier; latched on accepted START
HI  output  DATA_WIDTH  product bits [63:32]
LO  output  DATA_WIDTH  product bits [31:0]
BUSY  output  1  high while iterating
DONE  output  1  one-cycle completion strobe

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). RST has priority over every other input.
- Reset values: state=IDLE, HI=0, LO=0, BUSY=0, DONE=0, count=0, M (multiplicand register)=0.
- States: IDLE, RUN, DONE.
- IDLE: if START=1 at an edge (E0), then M<=OP1, HI<=0, LO<=OP2, count<=0, state<=RUN. Otherwise hold everything; HI/LO keep the last product.
- RUN: BUSY=1. Each edge performs one iteration:
  - {c,s} = HI + (LO[0] ? M : 0), 33-bit sum from the shared adder with carry-in 0.
  - {HI,LO} <= {c,s,LO} >> 1, i.e. HI<={c,s[31:1]}, LO<={s[0],LO[31:1]}.
  - count<=count+1.
- RUN→DONE on the edge that completes iteration 32 (E32), when count==DATA_WIDTH-1 before the edge. START is ignored throughout RUN.
- DONE: lasts exactly one cycle. DONE=1, BUSY=0, and HI/LO hold the final product.
  - At the next edge (E33): if START=1, accept new operands exactly as in IDLE and go to RUN (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: START sampled at E0, DONE visible after E32, so throughput is one product per 33 cycles.
- BUSY and DONE are registered outputs, never both high, and decoded from state only.
- Adder carry-out is bit 63 of the intermediate product. It must not be dropped; 0xFFFFFFFF² depends on it.
- Reset mid-RUN: the next cycle is IDLE with all outputs 0. The partial product is discarded, and no DONE pulse is produced for the aborted operation.
- Operand inputs may change freely after the accepting edge; only latched values are used.

Decomposition:
- Shared definitions package (prj_definition): DATA_WIDTH, and state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Sub-module rc_add_32: combinational 32-bit ripple-carry adder built from the existing full-adder cell, with ports Y[31:0], CO, A, B, CI.
- seq_mult_ctrl contains the FSM, counter, M/HI/LO registers and one rc_add_32 instance. No second adder is permitted.

Test Plan:
1. RST for 2 cycles, then START with OP1=3, OP2=5 -> BUSY=1 from E1 through E32; DONE=1 for exactly the cycle after E32; HI=0x00000000, LO=0x0000000F.
2. OP1=0xFFFFFFFF, OP2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 (carry-out path).
3. OP1=0x80000000, OP2=2 -> HI=0x00000001, LO=0x00000000. Then OP1=0, OP2=0x12345678 -> HI=LO=0.
4. START with 7×6; pulse START again at iteration 10 with OP1=OP2=0xFFFF -> second request ignored; result LO=42, HI=0; single DONE pulse.
5. START 9×9; assert RST during iteration 10 -> next cycle BUSY=0, DONE=0, HI=LO=0, and no DONE ever appears for 9×9. Then START 7×6 -> LO=42 after 33 cycles.
6. START 2×3; hold START=1 with OP1=4, OP2=5 during the DONE cycle -> HI/LO=0:6 visible with DONE; next edge re-enters RUN; 33 cycles later LO=20, DONE pulses once again.

Source files
------------

// File: rtl/prj_definition.sv
// Shared definitions for the sequential multiplier: operand width, counter width
// and the controller state encoding.
package prj_definition;

  localparam int unsigned DATA_INDEX_LIMIT = 31;
  localparam int unsigned DATA_WIDTH       = DATA_INDEX_LIMIT + 1;
  localparam int unsigned CNT_WIDTH        = 6;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } mult_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rc_add_32.sv
// Combinational 32-bit ripple-carry adder built from a chain of full-adder cells.
module rc_add_32 (
  output logic [31:0] Y,
  output logic        CO,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CI
);

  logic [32:0] carry;

  assign carry[0] = CI;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (Y[i]),
      .co (carry[i+1])
    );
  end

  assign CO = carry[32];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: 32 shift-add iterations over one shared adder,
// with a start/busy/done handshake toward the control unit.
module seq_mult_ctrl
  import prj_definition::*;
#(
  parameter int unsigned DATA_WIDTH = prj_definition::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = prj_definition::CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY,
  output logic                  DONE
);

  mult_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] add_b;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_co;

  assign add_b = lo_q[0] ? m_q : '0;

  rc_add_32 u_add (
    .Y  (add_sum),
    .CO (add_co),
    .A  (hi_q),
    .B  (add_b),
    .CI (1'b0)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          m_d     = OP1;
          hi_d    = '0;
          lo_d    = OP2;
          cnt_d   = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // Carry-out becomes the new MSB so the top product bit is never lost.
        hi_d  = {add_co, add_sum[DATA_WIDTH-1:1]};
        lo_d  = {add_sum[0], lo_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: expected products are queued at issue time
// and a negedge monitor checks every DONE strobe against the queue head.
module tb_seq_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1, op2;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];

  seq_mult_ctrl dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .OP1   (op1),
    .OP2   (op2),
    .HI    (hi),
    .LO    (lo),
    .BUSY  (busy),
    .DONE  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: an accepted request yields the full 64-bit unsigned product.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    op1   = a;
    op2   = b;
    start = 1'b1;
    exp_q.push_back(64'(a) * 64'(b));
  endtask

  always @(negedge clk) begin
    if (busy && done) chk("busy_done_overlap", 66'(1), 66'(0));
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 66'(1), 66'(0));
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("product", {2'b00, hi, lo}, {2'b00, e});
      end
    end
  end

  // Called at a negedge with START already driven; runs until DONE (bounded).
  task automatic wait_done(input int spur_at, input int rst_at, input bit chain,
                           input logic [31:0] a2, input logic [31:0] b2);
    int cyc    = 0;
    int busy_n = 0;
    bit seen   = 1'b0;
    while (cyc < 100 && !seen) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == spur_at) begin
        start = 1'b1;
        op1   = 32'h0000_FFFF;
        op2   = 32'h0000_FFFF;
      end
      if (spur_at > 0 && cyc == spur_at + 1) start = 1'b0;
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        chk("abort_outputs", {busy, done, hi, lo}, 66'(0));
        exp_q.delete();
        return;
      end
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        if (chain) issue(a2, b2);
      end
    end
    chk("latency", 66'(cyc), 66'(33));
    chk("busy_cycles", 66'(busy_n), 66'(32));
  endtask

  initial begin
    bit          pend;
    logic [31:0] a, b, na, nb;
    rst   = 1'b1;
    start = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'(0));
    rst = 1'b0;
    @(negedge clk);

    issue(32'd3, 32'd5);
    wait_done(-1, -1, 1'b0, '0, '0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-1, -1, 1'b0, '0, '0);
    issue(32'h8000_0000, 32'd2);
    wait_done(-1, -1, 1'b0, '0, '0);
    issue(32'd0, 32'h1234_5678);
    wait_done(-1, -1, 1'b0, '0, '0);

    // START during RUN must be ignored.
    issue(32'd7, 32'd6);
    wait_done(10, -1, 1'b0, '0, '0);

    // Reset mid-RUN discards the operation; no DONE may follow.
    issue(32'd9, 32'd9);
    wait_done(-1, 10, 1'b0, '0, '0);
    repeat (40) @(negedge clk);
    issue(32'd7, 32'd6);
    wait_done(-1, -1, 1'b0, '0, '0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back: new request held during the DONE cycle.
    issue(32'd2, 32'd3);
    wait_done(-1, -1, 1'b1, 32'd4, 32'd5);
    wait_done(-1, -1, 1'b0, '0, '0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b  = $urandom;
      na = $urandom;
      nb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (!pend) issue(a, b);
      pend = ($urandom_range(0, 1) == 1) && (i < 15);
      wait_done(-1, -1, pend, na, nb);
      if (!pend) begin
        start = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", 66'(exp_q.size()), 66'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
